// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core.
// Holds the PC, drives the instruction-memory address, selects the next PC
// and owns the IF/ID pipeline register feeding decode.
// Optional feature: define FETCH_ADEL_EN to enable fetch address-error
// detection (misaligned or outside instruction memory).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  PC_sel,
  input  logic [31:0] npc_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr,
  output logic [31:0] imem_addr,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic        adel_D
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        fetch_adel;

`ifdef FETCH_ADEL_EN
  logic        adel_q, adel_d;
  // One past the last valid byte address; 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);

  // Address error: misaligned PC or PC outside the instruction memory window.
  always_comb begin
    fetch_adel = (pc_q[1:0] != 2'b00) ||
                 (pc_q < RESET_PC) ||
                 ({1'b0, pc_q} >= IM_LIMIT);
  end
`else
  // No address checking in this build.
  always_comb begin
    fetch_adel = 1'b0;
  end
`endif

  // Next-PC selection; stall holds the PC, unknown selects fall back to PC+4.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (PC_sel)
        3'd1, 3'd2: pc_d = npc_target;
        3'd3:       pc_d = jr_target;
        default:    pc_d = pc_q + 32'd4;
      endcase
    end
  end

  // IF/ID next state: stall holds everything, flush loads a bubble, else load.
  always_comb begin
    ir_d    = ir_q;
    pcd_d   = pcd_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
`ifdef FETCH_ADEL_EN
    adel_d  = adel_q;
`endif
    if (!stall) begin
      if (flush) begin
        ir_d    = 32'd0;
        pcd_d   = 32'd0;
        pc8_d   = 32'd0;
        valid_d = 1'b0;
`ifdef FETCH_ADEL_EN
        adel_d  = 1'b0;
`endif
      end else begin
        // A faulting fetch enters decode as a nop but keeps its PC for the EPC.
        ir_d    = fetch_adel ? 32'd0 : instr;
        pcd_d   = pc_q;
        pc8_d   = pc_q + 32'd8;
        valid_d = 1'b1;
`ifdef FETCH_ADEL_EN
        adel_d  = fetch_adel;
`endif
      end
    end
  end

  // PC register; reset overrides stall, flush and PC_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= 32'd0;
      pcd_q   <= 32'd0;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pcd_q   <= pcd_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_ADEL_EN
  // Address-error flag travels with IR_D.
  always_ff @(posedge clk) begin
    if (reset) begin
      adel_q <= 1'b0;
    end else begin
      adel_q <= adel_d;
    end
  end
  assign adel_D = adel_q;
`else
  assign adel_D = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign IR_D      = ir_q;
  assign PC_D      = pcd_q;
  assign PC8_D     = pc8_q;
  assign valid_D   = valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter, drives the instruction-memory address, and selects the next PC from PC+4, the branch/jump target computed by the next-PC logic, or a register jump target. It also owns the IF/ID pipeline register that feeds decode, with stall and flush control from the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 1024, instruction-memory depth in words; used only by the address check.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- flush  in  1  load a bubble into IF/ID this cycle.
- PC_sel  in  3  next-PC source: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr; 4–7 = PC+4.
- npc_target  in  32  branch or j/jal target from the next-PC logic; used for PC_sel 1 and 2.
- jr_target  in  32  forwarded rs value; used for PC_sel 3.
- instr  in  32  instruction word read combinationally from instruction memory at imem_addr.
- imem_addr  out  32  current PC, combinational from the PC register.
- IR_D  out  32  instruction latched for decode.
- PC_D  out  32  PC of IR_D.
- PC8_D  out  32  PC_D+8, the link value for jal.
- valid_D  out  1  IR_D holds a real fetched instruction and not a bubble.
- adel_D  out  1  address-error flag for IR_D. Tied to 0 unless FETCH_ADEL_EN is defined.

## Operation
- PC register update priority: reset, then stall (hold), then the PC_sel mux.
- Next-PC mux:
  - PC_sel 0: PC+4.
  - PC_sel 1 or 2: npc_target.
  - PC_sel 3: jr_target.
  - Any other value: PC+4.
- All additions are 32-bit modulo 2^32. Wrap at 32'hFFFF_FFFC → 0 is silent.
- jr_target is used unmodified; bits [1:0] are not masked.
- IF/ID register update priority: reset, then stall (hold all D outputs), then flush, then normal load.
  - Flush loads IR_D=0, valid_D=0, adel_D=0, PC_D=0, PC8_D=0.
  - Normal load sets IR_D=instr, PC_D=PC, PC8_D=PC+8, valid_D=1.
- Simultaneous stall and flush: stall wins for both the PC and IF/ID; the flush request is dropped. The hazard unit must not assert both.
- Simultaneous flush and a PC redirect: the PC takes the redirect target and IF/ID takes the bubble in the same edge.
- No internal state beyond the PC and IF/ID registers.

## Timing
- Reset values, one cycle after reset is asserted at an edge:
  - PC=RESET_PC, so imem_addr=RESET_PC.
  - IR_D=0, PC_D=0, PC8_D=0, valid_D=0, adel_D=0.
- Reset asserted mid-run overrides stall, flush and PC_sel on that edge.
- Fetch latency: the instruction at address A appears on IR_D one edge after imem_addr=A, provided that edge is not stalled or flushed.
- Redirect latency: PC_sel/target presented in cycle N give imem_addr=target in cycle N+1.
- imem_addr has zero latency from the PC register; no combinational path from instr to imem_addr.
- Stall held for k cycles freezes all outputs for exactly k edges. The next edge resumes using that cycle's PC_sel.

## Configuration
- FETCH_ADEL_EN defined:
  - On a normal (unstalled, unflushed) load, adel_D=1 when either condition holds:
    - PC[1:0]≠0.
    - PC is outside [RESET_PC, RESET_PC+4*IM_WORDS).
  - In that case IR_D is forced to 0 (nop) instead of instr. valid_D=1, and PC_D/PC8_D are latched normally so the exception PC is preserved.
  - The PC continues sequencing normally; exception redirect belongs to the coprocessor.
- FETCH_ADEL_EN undefined: no address checking; adel_D is constant 0 and IR_D always takes instr.

## Test plan
- Reset then 3 free-running cycles, PC_sel=0, memory returns 32'h2401_0001 / 32'h2402_0002 → imem_addr 3000, 3004, 3008, 300C; IR_D lags by one cycle; PC_D=3000 with PC8_D=3008 on the first valid_D=1 cycle.
- At PC=3010: PC_sel=1, npc_target=32'h3040, flush=1 for one cycle → next imem_addr=3040; IR_D=0 and valid_D=0 for one cycle; the next IR_D has PC_D=3040.
- At PC=3020: PC_sel=3, jr_target=32'h3100; then stall=1 for 2 cycles → imem_addr=3100 and held for 2 cycles; IR_D/PC_D are unchanged during the stall.
- stall=1 and flush=1 together → PC and IF/ID are unchanged; reset asserted during a stall → PC=3000 and valid_D=0 on the next edge.
- With FETCH_ADEL_EN: jr_target=32'h3002 → adel_D=1, IR_D=0, PC_D=3002. jr_target=32'h4000 with IM_WORDS=1024 → adel_D=1. Without the macro, the same stimulus gives adel_D=0 and IR_D=instr.
